// File: rtl/add_sub_norm_stage.sv
// rtl/add_sub_norm_stage.sv - post-add normalisation stage: shift, exponent adjust, IEEE-754 single pack
//
// Two-stage valid/ready pipeline sitting after the leading-one detector of the
// add/sub datapath. Stage 1 registers the beat and classifies it
// (CARRY / ZERO / SHIFT). Stage 2 shifts the mantissa, adjusts the exponent and
// registers the packed result together with its overflow/underflow flags.
//
// Optional feature macro: ADD_SUB_NORM_SATURATE_EN
//   defined   : overflow packs the largest finite magnitude {sign, 8'hFE, 23'h7FFFFF}
//   undefined : overflow packs signed infinity {sign, 8'hFF, 23'h0}
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready  upstream handshake
//   i_sign           result sign
//   i_exp            larger-operand biased exponent
//   i_mant           raw mantissa sum (bit24 carry-out, bit23 hidden-bit position)
//   i_one_position   leading zeros counted from bit23 (0..23), 31 when all zero
//   i_zero_flag      i_mant[23:0] == 0
//   o_valid/i_ready  downstream handshake
//   o_data           packed single {sign, exp, frac}
//   o_overflow       result exponent saturated at the top (qualified by o_valid)
//   o_underflow      result flushed to signed zero (qualified by o_valid)

module add_sub_norm_stage #(
    parameter int SIZE_MANT = 25,
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_LOPD = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_sign,
    input  logic [SIZE_EXP-1:0]           i_exp,
    input  logic [SIZE_MANT-1:0]          i_mant,
    input  logic [SIZE_LOPD-1:0]          i_one_position,
    input  logic                          i_zero_flag,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [SIZE_EXP+SIZE_MANT-2:0] o_data,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int FRAC_W = SIZE_MANT - 2;
    localparam int DATA_W = SIZE_EXP + SIZE_MANT - 1;

    localparam logic [SIZE_LOPD-1:0] LZ_MAX  = SIZE_LOPD'(SIZE_MANT - 2);
    localparam logic [SIZE_EXP:0]    EXP_TOP = {1'b0, {SIZE_EXP{1'b1}}};

    typedef enum logic [1:0] {
        CASE_SHIFT = 2'd0,
        CASE_CARRY = 2'd1,
        CASE_ZERO  = 2'd2
    } norm_case_t;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_free;
    logic accept;

    assign s2_free = ~o_valid | i_ready;
    assign o_ready = ~s1_valid | s2_free;
    assign accept  = i_valid & o_ready;

    // ------------------------------------------------------------------
    // Stage 1: register + classify
    // ------------------------------------------------------------------
    norm_case_t            s1_case;
    logic                  s1_sign;
    logic [SIZE_EXP-1:0]   s1_exp;
    logic [SIZE_MANT-2:0]  s1_mant;    // carry bit is folded into s1_case
    logic [SIZE_LOPD-1:0]  s1_lz;
    norm_case_t            in_case;

    always_comb begin
        in_case = CASE_SHIFT;
        if (i_mant[SIZE_MANT-1]) begin
            in_case = CASE_CARRY;
        end else if (i_zero_flag || (i_one_position > LZ_MAX)) begin
            // Detector codes above the mantissa width (24..30) are treated as zero too.
            in_case = CASE_ZERO;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_case  <= CASE_SHIFT;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lz    <= '0;
        end else if (o_ready) begin
            // o_ready means stage 1 is empty or is moving into stage 2 this cycle.
            s1_valid <= i_valid;
            if (accept) begin
                s1_case <= in_case;
                s1_sign <= i_sign;
                s1_exp  <= i_exp;
                s1_mant <= i_mant[SIZE_MANT-2:0];
                s1_lz   <= i_one_position;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift + pack
    // ------------------------------------------------------------------
    logic [SIZE_EXP:0]   exp_inc;
    logic [SIZE_EXP-1:0] lz_ext;
    logic [SIZE_EXP-1:0] exp_dec;
    logic [FRAC_W-1:0]   frac_shl;
    logic [DATA_W-1:0]   ovf_word;
    logic [DATA_W-1:0]   n_data;
    logic                n_ovf;
    logic                n_unf;

    assign exp_inc  = {1'b0, s1_exp} + 1'b1;
    assign lz_ext   = {{(SIZE_EXP-SIZE_LOPD){1'b0}}, s1_lz};
    assign exp_dec  = s1_exp - lz_ext;
    // Only the fraction bits survive packing, so the shift is done at fraction width.
    assign frac_shl = s1_mant[FRAC_W-1:0] << s1_lz;

`ifdef ADD_SUB_NORM_SATURATE_EN
    assign ovf_word = {s1_sign, {(SIZE_EXP-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
`else
    assign ovf_word = {s1_sign, {SIZE_EXP{1'b1}}, {FRAC_W{1'b0}}};
`endif

    always_comb begin
        n_data = '0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        unique case (s1_case)
            CASE_CARRY: begin
                if (exp_inc >= EXP_TOP) begin
                    n_data = ovf_word;
                    n_ovf  = 1'b1;
                end else begin
                    // Right shift by one: bit23 becomes the hidden bit, bit0 is truncated.
                    n_data = {s1_sign, exp_inc[SIZE_EXP-1:0], s1_mant[FRAC_W:1]};
                end
            end
            CASE_SHIFT: begin
                if (s1_exp > lz_ext) begin
                    n_data = {s1_sign, exp_dec, frac_shl};
                end else begin
                    // Would need a denormal; flush to signed zero instead.
                    n_data = {s1_sign, {(DATA_W-1){1'b0}}};
                    n_unf  = 1'b1;
                end
            end
            default: begin
                n_data = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (s2_free) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data      <= n_data;
                o_overflow  <= n_ovf;
                o_underflow <= n_unf;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_norm_stage.sv
// tb/tb_add_sub_norm_stage.sv - scoreboard bench for add_sub_norm_stage

module tb_add_sub_norm_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [24:0] i_mant;
    logic [4:0]  i_one_position;
    logic        i_zero_flag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_overflow;
    logic        o_underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

`ifdef ADD_SUB_NORM_SATURATE_EN
    localparam logic [31:0] OVF_NEG = 32'hFF7F_FFFF;
`else
    localparam logic [31:0] OVF_NEG = 32'hFF80_0000;
`endif

    add_sub_norm_stage dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_sign         (i_sign),
        .i_exp          (i_exp),
        .i_mant         (i_mant),
        .i_one_position (i_one_position),
        .i_zero_flag    (i_zero_flag),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a beat seen valid with i_ready high at the falling edge transfers
    // on the next rising edge, so every result is compared exactly once.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got data=0x%08h ovf=%0b unf=%0b, expected no beat",
                         o_data, o_overflow, o_underflow);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (o_data !== e.data || o_overflow !== e.ovf || o_underflow !== e.unf) begin
                    failures++;
                    $display("FAIL result: got data=0x%08h ovf=%0b unf=%0b, expected data=0x%08h ovf=%0b unf=%0b",
                             o_data, o_overflow, o_underflow, e.data, e.ovf, e.unf);
                end
            end
        end
    end

    task automatic send(input logic sign, input logic [7:0] ex, input logic [24:0] mant,
                        input logic [4:0] pos, input logic zf,
                        input logic [31:0] ed, input logic eo, input logic eu);
        int cyc;
        @(negedge i_clk);
        i_valid        = 1'b1;
        i_sign         = sign;
        i_exp          = ex;
        i_mant         = mant;
        i_one_position = pos;
        i_zero_flag    = zf;
        cyc = 0;
        while (!o_ready && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got o_ready=0, expected 1 within 200 cycles");
            i_valid = 1'b0;
        end else begin
            @(posedge i_clk);
            sb.push_back('{data: ed, ovf: eo, unf: eu});
            #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge i_clk);
        #1;
        i_ready = r;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(posedge i_clk);
            cyc++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    logic [31:0] held;

    initial begin
        i_rst_n        = 1'b0;
        i_valid        = 1'b0;
        i_sign         = 1'b0;
        i_exp          = '0;
        i_mant         = '0;
        i_one_position = '0;
        i_zero_flag    = 1'b0;
        i_ready        = 1'b1;

        repeat (3) @(posedge i_clk);
        #2;
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_o_data", o_data, 32'h0);
        check("reset_flags", {30'd0, o_overflow, o_underflow}, 32'd0);
        check("reset_o_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed vectors: sign, exp, mant, pos, zero_flag -> data, ovf, unf
        send(0, 8'h80, 25'h180_0000, 5'd0,  0, 32'h40C0_0000, 0, 0);  // carry
        send(0, 8'h80, 25'h020_0000, 5'd2,  0, 32'h3F00_0000, 0, 0);  // shift by 2
        send(0, 8'h02, 25'h010_0000, 5'd3,  0, 32'h0000_0000, 0, 1);  // underflow
        send(1, 8'hFE, 25'h100_0000, 5'd31, 1, OVF_NEG,       1, 0);  // overflow
        send(1, 8'h00, 25'h000_0000, 5'd31, 1, 32'h0000_0000, 0, 0);  // zero
        send(0, 8'h7F, 25'h1FF_FFFF, 5'd0,  0, 32'h407F_FFFF, 0, 0);  // carry truncates bit0
        send(0, 8'h7F, 25'h0C0_0000, 5'd0,  0, 32'h3FC0_0000, 0, 0);  // already normal
        send(0, 8'h03, 25'h020_0000, 5'd2,  0, 32'h0080_0000, 0, 0);  // exp = lz+1, smallest normal
        send(1, 8'h02, 25'h020_0000, 5'd2,  0, 32'h8000_0000, 0, 1);  // exp = lz, signed flush
        send(0, 8'hFD, 25'h100_0000, 5'd31, 1, 32'h7F00_0000, 0, 0);  // carry to 254, no overflow
        send(0, 8'h10, 25'h100_0000, 5'd31, 1, 32'h0880_0000, 0, 0);  // carry wins over zero flag
        send(1, 8'h55, 25'h000_0000, 5'd24, 0, 32'h0000_0000, 0, 0);  // pos 24 treated as zero
        send(0, 8'h20, 25'h000_0001, 5'd23, 0, 32'h0480_0000, 0, 0);  // maximum shift
        drain();

        // Backpressure: two beats fill the pipe, third waits
        set_ready(1'b0);
        send(0, 8'h80, 25'h180_0000, 5'd0, 0, 32'h40C0_0000, 0, 0);
        send(0, 8'h80, 25'h020_0000, 5'd2, 0, 32'h3F00_0000, 0, 0);
        @(negedge i_clk);
        check("bp_o_ready_low", 32'(o_ready), 32'd0);
        check("bp_o_valid", 32'(o_valid), 32'd1);
        held = o_data;
        check("bp_head_data", held, 32'h40C0_0000);
        fork
            send(1, 8'h7F, 25'h0C0_0000, 5'd0, 0, 32'hBFC0_0000, 0, 0);
        join_none
        repeat (4) @(negedge i_clk);
        check("bp_data_stable", o_data, held);
        check("bp_still_blocked", 32'(o_ready), 32'd0);
        set_ready(1'b1);
        wait fork;
        drain();

        // Reset with both stages full
        set_ready(1'b0);
        send(0, 8'h80, 25'h180_0000, 5'd0, 0, 32'h40C0_0000, 0, 0);
        send(0, 8'h80, 25'h020_0000, 5'd2, 0, 32'h3F00_0000, 0, 0);
        @(posedge i_clk);
        #2;
        check("pre_reset_full", {30'd0, o_valid, o_ready}, 32'd2);
        i_rst_n = 1'b0;
        #1;
        check("async_reset_o_valid", 32'(o_valid), 32'd0);
        check("async_reset_o_data", o_data, 32'h0);
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        set_ready(1'b1);
        send(0, 8'h80, 25'h020_0000, 5'd2, 0, 32'h3F00_0000, 0, 0);
        drain();

        repeat (3) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
